arbiter_round_robin_ack: RTL
============================

// Module: arbiter_round_robin_ack
// PURPOSE
//  - Round-robin arbiter that shares one downstream resource between CLIENTS requesters.
//  - Chooses a winner with a masked/unmasked pair of lowest-index-first priority pickers.
//  - Registers a one-hot grant plus a binary grant ID.
//  - Optionally holds the grant until the winner acknowledges it.
//  - Sits in front of shared datapaths, e.g. a bus port or a buffer write port.
// PARAMETERS
//  - CLIENTS      8  number of requesters; legal range 2..64.
//  - WAIT_GNT_ACK 1  1 = hold grant until ack; 0 = single-cycle grant pulse, ack ignored.
//  - ID_W         $clog2(CLIENTS)  width of the grant ID; derived, not overridden.
// PORTS
//  - i_clk        in   1        clock; single clock domain.
//  - i_rst_n      in   1        reset; asynchronous, active-low.
//  - i_block_arb  in   1        1 = issue no new grants; a grant already held stays held.
//  - i_req        in   CLIENTS  request vector; bit i = client i.
//  - i_gnt_ack    in   CLIENTS  ack vector; only bit o_gnt_id is honoured.
//  - o_gnt_valid  out  1        a grant is active.
//  - o_gnt        out  CLIENTS  one-hot grant; all zero when o_gnt_valid = 0.
//  - o_gnt_id     out  ID_W     index of the granted client; 0 when no grant is active.
//  - o_last_id    out  ID_W     round-robin pointer: index of the last granted client.
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled outside this block):
//    - o_gnt_valid = 0, o_gnt = 0, o_gnt_id = 0.
//    - o_last_id = CLIENTS-1, so client 0 has top priority after reset.
//    - FSM goes to IDLE.
//  - Pick, combinational:
//    - mask = bits with index > o_last_id.
//    - If i_req & mask is non-zero, winner = lowest set index of i_req & mask.
//    - Otherwise winner = lowest set index of i_req.
//    - "none" when i_req = 0.
//  - FSM states: IDLE, GRANT.
//  - IDLE: if !i_block_arb and a winner exists:
//    - register o_gnt, o_gnt_id and o_last_id = winner; set o_gnt_valid.
//    - go to GRANT.
//    - Latency is 1 cycle from sampled request to visible grant.
//  - GRANT, WAIT_GNT_ACK = 1:
//    - Grant is held while i_req[o_gnt_id] = 1 and i_gnt_ack[o_gnt_id] = 0.
//    - Ack sampled at edge k: the grant ends at edge k.
//      - Same edge: re-pick using the already-updated o_last_id.
//      - Load the new winner if !i_block_arb and one exists; stay in GRANT.
//      - Otherwise clear o_gnt/o_gnt_valid and go to IDLE.
//      - Back-to-back grants have no bubble.
//    - Request withdrawn (i_req[o_gnt_id] = 0) without ack: treated exactly as an ack.
//    - Ack bits for non-granted clients are ignored.
//  - WAIT_GNT_ACK = 0:
//    - Every grant lasts exactly one cycle.
//    - Re-pick every edge; the FSM never stays in GRANT without a new winner.
//  - Fairness: a client that keeps requesting is granted within CLIENTS grants.
//  - o_last_id changes only when a new grant is loaded.
//  - i_block_arb:
//    - Asserted during GRANT: the current grant is still released by ack; no new grant loads.
//    - Deasserted: normal picking resumes on the next edge.
//  - Reset mid-grant: outputs clear immediately (asynchronous); the pointer returns to CLIENTS-1.
//  - Invariants:
//    - $onehot0(o_gnt) always holds.
//    - o_gnt_valid == |o_gnt.
//    - When o_gnt_valid = 1, o_gnt == 1 << o_gnt_id.
// STRUCTURE
//  - Shared package arbiter_pkg:
//    - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t.
//    - function onehot_from_index().
//  - One sub-module, arbiter_rr_pick (combinational):
//    - Inputs: req, mask enable.
//    - Outputs: found and lowest-set index.
//    - Instantiated twice: masked path and unmasked path.
//  - Remaining RTL in this file: mask generation, winner select, FSM, output registers.
// TESTING
//  - Reset, then i_req = 8'b1010_0000:
//    - o_gnt = 8'b0010_0000, o_gnt_id = 5 after 1 cycle.
//    - Held until i_gnt_ack[5] = 1.
//  - i_req = 8'hFF held, ack every grant cycle:
//    - grant order 0,1,...,7,0 with no idle cycles between grants.
//  - Grant to client 3 with i_req = 8'h09:
//    - ack[3] -> next grant goes to 0; client 3 is not re-granted ahead of 0.
//  - i_block_arb = 1 while client 2 is granted, ack arrives:
//    - o_gnt_valid = 0 next cycle; no grant until i_block_arb = 0.
//    - Then the grant resumes within 1 cycle.
//  - Client 6 granted, i_req[6] drops without ack:
//    - grant released; pending client 1 is granted the same edge.
//  - WAIT_GNT_ACK = 0, i_req = 8'h81:
//    - alternating single-cycle grants 0,7,0,7.
//    - Check o_last_id tracks each grant; assert invariants every cycle.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Combinational only; no storage and no flow control.
package arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int ARB_MAX_CLIENTS = 64;
  localparam int ARB_MAX_ID_W    = 6;

  function automatic logic [ARB_MAX_CLIENTS-1:0] onehot_from_index(
    input logic [ARB_MAX_ID_W-1:0] idx
  );
    logic [ARB_MAX_CLIENTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Lowest-index-first picker over (req & mask); purely combinational, zero latency.
// No backpressure: found_o is low and idx_o is zero when nothing is eligible.
module arbiter_rr_pick
  import arbiter_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N-1:0] eligible;

  always_comb begin
    eligible = req_i & mask_i;
    found_o  = |eligible;
    idx_o    = '0;
    // Walk downwards so the last hit written is the lowest set index.
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/arbiter_round_robin_ack.sv
// Round-robin arbiter with registered one-hot grant; 1 cycle from request to grant.
// Grant is held until ack or request withdrawal (WAIT_GNT_ACK=1); i_block_arb stops new grants.
module arbiter_round_robin_ack
  import arbiter_pkg::*;
#(
  parameter int   CLIENTS      = 8,
  parameter int   WAIT_GNT_ACK = 1,
  localparam int  ID_W         = $clog2(CLIENTS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_block_arb,
  input  logic [CLIENTS-1:0] i_req,
  input  logic [CLIENTS-1:0] i_gnt_ack,
  output logic               o_gnt_valid,
  output logic [CLIENTS-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic [ID_W-1:0]    o_last_id
);

  arb_state_t         state_q;
  logic               gnt_valid_q;
  logic [CLIENTS-1:0] gnt_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic [ID_W-1:0]    last_id_q;

  logic [CLIENTS-1:0] prio_mask;
  logic [CLIENTS-1:0] all_mask;
  logic               m_found;
  logic [ID_W-1:0]    m_idx;
  logic               u_found;
  logic [ID_W-1:0]    u_idx;

  logic               win_found;
  logic [ID_W-1:0]    gnt_id_d;
  logic [CLIENTS-1:0] gnt_d;
  logic               load_d;
  logic               release_d;

  always_comb begin
    prio_mask = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      prio_mask[i] = (i > int'(last_id_q));
    end
    all_mask = '1;
  end

  arbiter_rr_pick #(
    .N     (CLIENTS),
    .IDX_W (ID_W)
  ) u_pick_masked (
    .req_i   (i_req),
    .mask_i  (prio_mask),
    .found_o (m_found),
    .idx_o   (m_idx)
  );

  arbiter_rr_pick #(
    .N     (CLIENTS),
    .IDX_W (ID_W)
  ) u_pick_unmasked (
    .req_i   (i_req),
    .mask_i  (all_mask),
    .found_o (u_found),
    .idx_o   (u_idx)
  );

  // Masked winner wins so the search wraps past the last granted client.
  always_comb begin
    win_found = m_found | u_found;
    gnt_id_d  = m_found ? m_idx : u_idx;
    gnt_d     = CLIENTS'(onehot_from_index(ARB_MAX_ID_W'(gnt_id_d)));
    load_d    = !i_block_arb && win_found;
    if (WAIT_GNT_ACK != 0) begin
      release_d = !i_req[gnt_id_q] || i_gnt_ack[gnt_id_q];
    end else begin
      release_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB_IDLE;
      gnt_valid_q <= 1'b0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      last_id_q   <= ID_W'(CLIENTS - 1);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (load_d) begin
            gnt_valid_q <= 1'b1;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            last_id_q   <= gnt_id_d;
            state_q     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (release_d) begin
            if (load_d) begin
              gnt_valid_q <= 1'b1;
              gnt_q       <= gnt_d;
              gnt_id_q    <= gnt_id_d;
              last_id_q   <= gnt_id_d;
            end else begin
              gnt_valid_q <= 1'b0;
              gnt_q       <= '0;
              gnt_id_q    <= '0;
              state_q     <= ARB_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign o_gnt_valid = gnt_valid_q;
  assign o_gnt       = gnt_q;
  assign o_gnt_id    = gnt_id_q;
  assign o_last_id   = last_id_q;

endmodule
